// File: rtl/convolution_processor_pkg.sv
// Shared constants and helpers for the add/sub pipeline.
//   DefaultDataWidth / DefaultLanes : default lane width and lane count
//   sat_max / sat_min               : two's-complement clamp limits for a given width
package convolution_processor_pkg;

   localparam int unsigned DefaultDataWidth = 18;
   localparam int unsigned DefaultLanes     = 4;

   // Largest positive value representable in 'width' bits, two's complement.
   function automatic longint sat_max(input int unsigned width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   // Most negative value representable in 'width' bits, two's complement.
   function automatic longint sat_min(input int unsigned width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/convolution_processor_addsub_lane.sv
// One lane of the add/sub pipeline: widened add/sub in stage 1, overflow detect and
// clamp/wrap narrowing in stage 2. Load enables come from the shared top-level control.
//   clk, rst_a      : clock, asynchronous active-low reset
//   s1_load/s2_load : stage load enables
//   s1_valid        : stage 1 holds a real transfer (qualifies the overflow flag)
//   op_sub, a, b    : operation select and operands for this lane
//   wide_ovf        : stage 1 result does not fit in DATA_WIDTH bits
//   result, ovf     : stage 2 narrowed result and its overflow flag
module convolution_processor_addsub_lane
   import convolution_processor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_a,
   input  logic                  s1_load,
   input  logic                  s2_load,
   input  logic                  s1_valid,
   input  logic                  op_sub,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  wide_ovf,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  ovf
);

   localparam logic [DATA_WIDTH-1:0] SatMax = DATA_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SatMin = DATA_WIDTH'(sat_min(DATA_WIDTH));

   logic [DATA_WIDTH:0]   a_ext, b_ext, sum_d, sum_q;
   logic [DATA_WIDTH-1:0] narrow;

   // One extra bit of headroom means the widened sum itself can never overflow.
   always_comb begin
      a_ext = {a[DATA_WIDTH-1], a};
      b_ext = {b[DATA_WIDTH-1], b};
      sum_d = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);
   end

   assign wide_ovf = sum_q[DATA_WIDTH] ^ sum_q[DATA_WIDTH-1];

   // The top bit of the widened sum is the true sign, so it picks the clamp direction.
   always_comb begin
      narrow = sum_q[DATA_WIDTH-1:0];
      if (SATURATE && wide_ovf) begin
         narrow = sum_q[DATA_WIDTH] ? SatMin : SatMax;
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         sum_q <= '0;
      end else if (s1_load) begin
         sum_q <= sum_d;
      end
   end

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         result <= '0;
         ovf    <= 1'b0;
      end else if (s2_load) begin
         result <= narrow;
         ovf    <= wide_ovf & s1_valid;
      end
   end

endmodule

// File: rtl/convolution_processor_addsub_pipe.sv
// Two-stage, multi-lane saturating/wrapping add/sub pipeline with valid/ready handshakes.
//   clk, rst_a                 : clock, asynchronous active-low reset
//   in_valid, in_ready         : input handshake
//   op_sub                     : 1 = A-B, 0 = A+B, sampled with the transfer
//   a_data, b_data             : packed operands, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid, out_ready       : output handshake
//   out_data, out_ovf          : packed results and per-lane overflow flags
//   ovf_clear, ovf_sticky      : sticky overflow indicator and its synchronous clear
module convolution_processor_addsub_pipe
   import convolution_processor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefaultDataWidth,
   parameter int unsigned LANES      = DefaultLanes,
   parameter bit          SATURATE   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_a,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        op_sub,
   input  logic [LANES*DATA_WIDTH-1:0] a_data,
   input  logic [LANES*DATA_WIDTH-1:0] b_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_ovf,
   input  logic                        ovf_clear,
   output logic                        ovf_sticky
);

   logic             s1_valid;
   logic             s1_load, s2_load;
   logic             sticky_set;
   logic [LANES-1:0] lane_wide_ovf;

   // Each stage advances when it is empty or its successor is moving.
   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s1_load) s1_valid  <= in_valid;
         if (s2_load) out_valid <= s1_valid;
      end
   end

   assign sticky_set = s2_load && s1_valid && (|lane_wide_ovf);

   // A set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         ovf_sticky <= 1'b0;
      end else if (sticky_set) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clear) begin
         ovf_sticky <= 1'b0;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      convolution_processor_addsub_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .SATURATE   (SATURATE)
      ) u_lane (
         .clk      (clk),
         .rst_a    (rst_a),
         .s1_load  (s1_load),
         .s2_load  (s2_load),
         .s1_valid (s1_valid),
         .op_sub   (op_sub),
         .a        (a_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .b        (b_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .wide_ovf (lane_wide_ovf[k]),
         .result   (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .ovf      (out_ovf[k])
      );
   end

endmodule

// File: tb/tb_convolution_processor_addsub_pipe.sv
// Bench for convolution_processor_addsub_pipe: a saturating and a wrapping instance share
// stimulus and are checked against an arithmetic reference model and an in-order scoreboard.
module tb_convolution_processor_addsub_pipe;

   localparam int W = 18;
   localparam int L = 4;

   typedef struct packed {
      logic [L*W-1:0] ds;
      logic [L*W-1:0] dw;
      logic [L-1:0]   ovf;
   } item_t;

   logic           clk = 1'b0;
   logic           rst_a;
   logic           in_valid, op_sub, out_ready, ovf_clear;
   logic [L*W-1:0] a_data, b_data;
   logic           in_ready_s, out_valid_s, ovf_sticky_s;
   logic           in_ready_w, out_valid_w, ovf_sticky_w;
   logic [L*W-1:0] out_data_s, out_data_w;
   logic [L-1:0]   out_ovf_s, out_ovf_w;

   int    n_checks = 0;
   int    n_errors = 0;
   item_t exp_q[$];
   logic  sticky_m = 1'b0;
   logic  stalled  = 1'b0;

   always #5 clk = ~clk;

   convolution_processor_addsub_pipe #(.DATA_WIDTH(W), .LANES(L), .SATURATE(1'b1)) u_dut_sat (
      .clk        (clk),
      .rst_a      (rst_a),
      .in_valid   (in_valid),
      .in_ready   (in_ready_s),
      .op_sub     (op_sub),
      .a_data     (a_data),
      .b_data     (b_data),
      .out_valid  (out_valid_s),
      .out_ready  (out_ready),
      .out_data   (out_data_s),
      .out_ovf    (out_ovf_s),
      .ovf_clear  (ovf_clear),
      .ovf_sticky (ovf_sticky_s)
   );

   convolution_processor_addsub_pipe #(.DATA_WIDTH(W), .LANES(L), .SATURATE(1'b0)) u_dut_wrap (
      .clk        (clk),
      .rst_a      (rst_a),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w),
      .op_sub     (op_sub),
      .a_data     (a_data),
      .b_data     (b_data),
      .out_valid  (out_valid_w),
      .out_ready  (out_ready),
      .out_data   (out_data_w),
      .out_ovf    (out_ovf_w),
      .ovf_clear  (ovf_clear),
      .ovf_sticky (ovf_sticky_w)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic, then clamp or take the low bits.
   function automatic item_t model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                   input logic sub);
      item_t  it;
      longint sa, sb, r, sat;
      longint maxv = (longint'(1) <<< (W - 1)) - 1;
      longint minv = -maxv - 1;
      it = '0;
      for (int k = 0; k < L; k++) begin
         sa = longint'($signed(a[k*W +: W]));
         sb = longint'($signed(b[k*W +: W]));
         r  = sub ? sa - sb : sa + sb;
         it.ovf[k] = (r > maxv) || (r < minv);
         sat = (r > maxv) ? maxv : ((r < minv) ? minv : r);
         it.ds[k*W +: W] = sat[W-1:0];
         it.dw[k*W +: W] = r[W-1:0];
      end
      return it;
   endfunction

   function automatic logic [L*W-1:0] rand_vec();
      logic [L*W-1:0] v;
      for (int k = 0; k < L; k++) begin
         case ($urandom_range(0, 3))
            0:       v[k*W +: W] = 18'h1ffff;
            1:       v[k*W +: W] = 18'h20000;
            2:       v[k*W +: W] = W'($urandom_range(0, 64));
            default: v[k*W +: W] = W'($urandom);
         endcase
      end
      return v;
   endfunction

   // Single transfer into an empty pipe with out_ready=1; returns #1 after the output edge.
   task automatic send_one(input string tag, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                           input logic sub, input logic clr_at_load);
      item_t it;
      it = model(a, b, sub);
      in_valid = 1'b1; a_data = a; b_data = b; op_sub = sub; out_ready = 1'b1; ovf_clear = 1'b0;
      #1;
      check({tag, "_in_ready"}, in_ready_s, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; a_data = rand_vec(); b_data = rand_vec(); ovf_clear = clr_at_load;
      check({tag, "_lat1_valid"}, out_valid_s, 1'b0);
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      if (|it.ovf) sticky_m = 1'b1;
      else if (clr_at_load) sticky_m = 1'b0;
      check({tag, "_valid"}, out_valid_s, 1'b1);
      check({tag, "_data_sat"}, out_data_s, it.ds);
      check({tag, "_data_wrap"}, out_data_w, it.dw);
      check({tag, "_ovf_sat"}, out_ovf_s, it.ovf);
      check({tag, "_ovf_wrap"}, out_ovf_w, it.ovf);
      check({tag, "_sticky_sat"}, ovf_sticky_s, sticky_m);
      check({tag, "_sticky_wrap"}, ovf_sticky_w, sticky_m);
   endtask

   task automatic clear_alone(input string tag);
      ovf_clear = 1'b1;
      @(posedge clk); #1;
      ovf_clear = 1'b0;
      sticky_m  = 1'b0;
      check({tag, "_sat"}, ovf_sticky_s, 1'b0);
      check({tag, "_wrap"}, ovf_sticky_w, 1'b0);
      @(negedge clk);
   endtask

   // One streaming cycle, entered and left just after a falling edge.
   task automatic run_cycle(input logic iv, input logic ordy, output logic accepted);
      item_t it;
      logic  exp_inr, acc_out;
      in_valid = iv; out_ready = ordy; op_sub = 1'($urandom); ovf_clear = 1'b0;
      a_data = rand_vec(); b_data = rand_vec();
      it = model(a_data, b_data, op_sub);
      #1;
      exp_inr = !(exp_q.size() == 2 && !ordy);
      check("in_ready_sat", in_ready_s, exp_inr);
      check("in_ready_wrap", in_ready_w, exp_inr);
      if (stalled) check("hold_valid", out_valid_s, 1'b1);
      if (out_valid_s) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", out_valid_s, 1'b0);
         end else begin
            check("valid_wrap", out_valid_w, 1'b1);
            check("stream_data_sat", out_data_s, exp_q[0].ds);
            check("stream_data_wrap", out_data_w, exp_q[0].dw);
            check("stream_ovf_sat", out_ovf_s, exp_q[0].ovf);
            check("stream_ovf_wrap", out_ovf_w, exp_q[0].ovf);
            if (|exp_q[0].ovf) sticky_m = 1'b1;
         end
      end
      check("stream_sticky_sat", ovf_sticky_s, sticky_m);
      check("stream_sticky_wrap", ovf_sticky_w, sticky_m);
      acc_out  = out_valid_s && ordy;
      stalled  = out_valid_s && !ordy;
      accepted = iv && exp_inr;
      @(posedge clk);
      if (acc_out) void'(exp_q.pop_front());
      if (accepted) exp_q.push_back(it);
      @(negedge clk);
   endtask

   task automatic drain();
      logic acc;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) run_cycle(1'b0, 1'b1, acc);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [L*W-1:0] va, vb;
      logic           acc;
      logic           pat [4];
      int             sent;

      rst_a = 1'b0; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
      a_data = '0; b_data = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid_s, 1'b0);
      check("rst_out_data", out_data_s, '0);
      check("rst_out_ovf", out_ovf_s, '0);
      check("rst_sticky", ovf_sticky_s, 1'b0);
      check("rst_in_ready", in_ready_s, 1'b1);
      rst_a = 1'b1;

      // Plain subtract, accepted on the first edge after reset release.
      va = '0; vb = '0; va[W-1:0] = 18'd100; vb[W-1:0] = 18'd30;
      send_one("r036", va, vb, 1'b1, 1'b0);
      check("r036_lane0", out_data_s[W-1:0], 18'd70);
      check("r036_ovf0", out_ovf_s[0], 1'b0);
      @(negedge clk);

      va = '0; vb = '0; va[W-1:0] = 18'h1ffff; vb[W-1:0] = 18'd1;
      send_one("r037", va, vb, 1'b0, 1'b0);
      check("r037_lane0", out_data_s[W-1:0], 18'd131071);
      check("r037_ovf0", out_ovf_s[0], 1'b1);
      @(negedge clk);

      va = '0; vb = '0; va[W-1:0] = 18'h20000; vb[W-1:0] = 18'd1;
      send_one("r038", va, vb, 1'b1, 1'b0);
      check("r038_wrap_lane0", out_data_w[W-1:0], 18'd131071);
      check("r038_sat_lane0", out_data_s[W-1:0], 18'h20000);
      check("r038_ovf0", out_ovf_w[0], 1'b1);
      @(negedge clk);

      clear_alone("clear1");
      va = '0; vb = '0; va[W-1:0] = 18'h1ffff; vb[W-1:0] = 18'h1ffff;
      send_one("r040", va, vb, 1'b0, 1'b1);
      @(negedge clk);
      clear_alone("clear2");

      // Eight back-to-back transfers with out_ready cycling 1,0,0,1.
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      sent = 0;
      for (int i = 0; i < 100 && sent < 8; i++) begin
         run_cycle(1'b1, pat[i%4], acc);
         if (acc) sent++;
      end
      check("r039_sent", sent, 8);
      drain();

      for (int i = 0; i < 300; i++) begin
         run_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7), acc);
      end
      drain();

      // Fill both stages under stall, then reset asynchronously between edges.
      out_ready = 1'b0; in_valid = 1'b1; op_sub = 1'b0;
      a_data = '0; b_data = '0; a_data[W-1:0] = 18'h1ffff; b_data[W-1:0] = 18'd1;
      @(posedge clk); #1;
      a_data[W-1:0] = 18'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("full_in_ready", in_ready_s, 1'b0);
      check("full_out_valid", out_valid_s, 1'b1);
      check("full_sticky", ovf_sticky_s, 1'b1);
      #2 rst_a = 1'b0;
      #1;
      check("async_out_valid_sat", out_valid_s, 1'b0);
      check("async_out_valid_wrap", out_valid_w, 1'b0);
      check("async_out_data", out_data_s, '0);
      check("async_out_ovf", out_ovf_s, '0);
      check("async_sticky", ovf_sticky_s, 1'b0);
      check("async_in_ready", in_ready_s, 1'b1);
      @(negedge clk);
      rst_a = 1'b1; out_ready = 1'b1;
      exp_q.delete(); sticky_m = 1'b0; stalled = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("flushed_no_output", out_valid_s, 1'b0);
      end
      @(negedge clk);

      va = rand_vec(); vb = rand_vec();
      send_one("post_rst", va, vb, 1'b1, 1'b0);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/convolution_processor_addsub_pipe.md
CONVOLUTION_PROCESSOR_ADDSUB_PIPE -- requirements
Module: convolution_processor_addsub_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 18, SHALL set the per-lane two's-complement operand and result width.
REQ-002 Parameter LANES, default 4, SHALL set the number of independent lanes processed per transfer.
REQ-003 Parameter SATURATE, default 1, SHALL select clamping when 1 and wrap-around when 0.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_a  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that the upstream operands are valid.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a transfer this cycle.
REQ-008 op_sub  input  1  SHALL select A-B when 1 and A+B when 0, sampled with the transfer.
REQ-009 a_data  input  LANES*DATA_WIDTH  SHALL carry operand A, with lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 b_data  input  LANES*DATA_WIDTH  SHALL carry operand B, using the same lane packing.
REQ-011 out_valid  output  1  SHALL indicate that a result is valid.
REQ-012 out_ready  input  1  SHALL indicate that the downstream consumer accepts the result.
REQ-013 out_data  output  LANES*DATA_WIDTH  SHALL carry the per-lane results, packed as a_data.
REQ-014 out_ovf  output  LANES  SHALL flag, per lane, that the current result overflowed.
REQ-015 ovf_clear  input  1  SHALL be a synchronous clear for ovf_sticky.
REQ-016 ovf_sticky  output  1  SHALL be a sticky OR of all overflows delivered since the last clear or reset.

Function
REQ-017 Transfers SHALL occur on in_valid&&in_ready at input and on out_valid&&out_ready at output.
REQ-018 Stage 1 SHALL register each lane's sign-extended DATA_WIDTH+1-bit sum or difference, op_sub, and s1_valid.
REQ-019 Stage 2 SHALL register the result narrowed to DATA_WIDTH bits, the out_ovf bits, and out_valid.
REQ-020 Overflow for a lane SHALL be detected when bit DATA_WIDTH of the wide result differs from bit DATA_WIDTH-1.
REQ-021 With SATURATE=1, a positive overflow SHALL clamp to 2^(DATA_WIDTH-1)-1 and a negative overflow to -2^(DATA_WIDTH-1).
REQ-022 With SATURATE=0, the result SHALL be the low DATA_WIDTH bits of the wide result; out_ovf SHALL still be reported.
REQ-023 Stage 2 SHALL load when !out_valid || out_ready (s2_load).
REQ-024 Stage 1 SHALL load when !s1_valid || s2_load; in_ready SHALL equal this term, combinationally.
REQ-025 With out_ready held at 1, latency SHALL be exactly 2 cycles and throughput 1 transfer per cycle.
REQ-026 Under back-pressure, out_data, out_ovf and out_valid SHALL hold stable until accepted; no transfer SHALL be lost or duplicated.
REQ-027 A stage whose predecessor is empty when it loads SHALL load valid=0.
REQ-028 ovf_sticky SHALL set on any s2_load carrying a valid result with any overflow bit set.
REQ-029 When set and ovf_clear coincide, set SHALL win and ovf_sticky SHALL be 1 the next cycle.

Reset
REQ-030 While rst_a=0, s1_valid, out_valid, out_data, out_ovf and ovf_sticky SHALL be 0, and in_ready SHALL be 1 as s1_valid=0.
REQ-031 Assertion of reset mid-operation SHALL discard in-flight data immediately, without waiting for a clock edge.
REQ-032 After release of reset, the first transfer SHALL be accepted on the first clk edge with in_valid=1.

Structure
REQ-033 Package convolution_processor_pkg SHALL hold the default DATA_WIDTH, the default LANES, and the saturation max/min constant functions.
REQ-034 Per-lane arithmetic and saturation SHALL live in one sub-module, convolution_processor_addsub_lane, instantiated LANES times by generate.
REQ-035 The handshake and valid control SHALL live only in the top module and SHALL be shared by all lanes.

Verification
REQ-036 Defaults; out_ready=1; lane0 A=100, B=30, op_sub=1 -> out_data lane0=70 two cycles later, out_ovf=0.
REQ-037 SATURATE=1; A=131071, B=1, op_sub=0 -> result 131071, out_ovf[0]=1, ovf_sticky=1 next cycle.
REQ-038 SATURATE=0; A=-131072, B=1, op_sub=1 -> result 131071, out_ovf[0]=1.
REQ-039 Stream 8 transfers with out_ready toggled 1,0,0,1 -> all 8 results appear in order, held stable while stalled, and in_ready=0 when both stages are full and stalled.
REQ-040 Overflow and ovf_clear in the same cycle -> ovf_sticky=1; ovf_clear alone later -> ovf_sticky=0.
REQ-041 rst_a pulsed low with both stages full -> out_valid=0 asynchronously, and the held data is never emitted.
